// File: rtl/mux4_arbiter_pkg.sv
// Shared types and constants for the mux4_arbiter round-robin mux controller.
package mux4_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   // Last-owner pointer at reset; requester 0 is searched first.
   localparam logic [1:0] PTR_RST = 2'b11;

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/rr_priority4.sv
// Combinational round-robin search over four requests starting after ptr.
// With mask=1 the ptr position itself is excluded (used to detect "someone else waiting").
module rr_priority4 (
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   input  logic       mask,
   output logic       found,
   output logic [1:0] win
);

   always_comb begin
      found = 1'b0;
      win   = ptr;
      for (int k = 1; k <= 4; k++) begin
         if (!found && req[ptr + 2'(k)] && !(mask && k == 4)) begin
            found = 1'b1;
            win   = ptr + 2'(k);
         end
      end
   end

endmodule

// File: rtl/mux4_arbiter.sv
// Round-robin owner of a shared 4:1 mux: drives sel, active-low n_en and one-hot gnt.
// Define MUX4_ARBITER_GAP_EN to insert one dead GAP cycle between different owners.
module mux4_arbiter
   import mux4_arbiter_pkg::*;
#(
   parameter int HOLD_CYCLES = 4,
   parameter int CNT_W       = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       n_en,
   output logic       busy
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_CYCLES == 0) ? 0 : HOLD_CYCLES - 1);

   state_e           state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       sel_q, sel_d;
   logic             n_en_q, n_en_d;
   logic             busy_q, busy_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef MUX4_ARBITER_GAP_EN
   logic [1:0]       pend_q, pend_d;
`endif

   logic       found, other_found, hold_hit, do_grant;
   logic [1:0] win, other_win, grant_w;

   rr_priority4 u_search (
      .req   (req),
      .ptr   (ptr_q),
      .mask  (1'b0),
      .found (found),
      .win   (win)
   );

   // Same search with the current owner masked: tells whether anyone else is waiting.
   rr_priority4 u_other (
      .req   (req),
      .ptr   (ptr_q),
      .mask  (1'b1),
      .found (other_found),
      .win   (other_win)
   );

   assign hold_hit = (HOLD_CYCLES != 0) && (cnt_q == HOLD_LAST);

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      sel_d    = sel_q;
      n_en_d   = n_en_q;
      busy_d   = busy_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
`ifdef MUX4_ARBITER_GAP_EN
      pend_d   = pend_q;
`endif
      do_grant = 1'b0;
      grant_w  = win;
      case (state_q)
         ST_IDLE: do_grant = found;
         ST_GRANT: begin
            if (!req[ptr_q] || (hold_hit && other_found)) begin
               if (found) begin
`ifdef MUX4_ARBITER_GAP_EN
                  if (win != ptr_q) begin
                     state_d = ST_GAP;
                     gnt_d   = 4'b0000;
                     n_en_d  = 1'b1;
                     pend_d  = win;
                  end else begin
                     do_grant = 1'b1;
                  end
`else
                  do_grant = 1'b1;
`endif
               end else begin
                  state_d = ST_IDLE;
                  gnt_d   = 4'b0000;
                  n_en_d  = 1'b1;
                  busy_d  = 1'b0;
               end
            end else if (HOLD_CYCLES == 0 || hold_hit) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`ifdef MUX4_ARBITER_GAP_EN
         ST_GAP: begin
            do_grant = 1'b1;
            grant_w  = pend_q;
         end
`endif
         default: begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            n_en_d  = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
      if (do_grant) begin
         state_d = ST_GRANT;
         gnt_d   = onehot4(grant_w);
         sel_d   = grant_w;
         n_en_d  = 1'b0;
         busy_d  = 1'b1;
         cnt_d   = '0;
         ptr_d   = grant_w;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= 4'b0000;
         sel_q   <= 2'b00;
         n_en_q  <= 1'b1;
         busy_q  <= 1'b0;
         ptr_q   <= PTR_RST;
         cnt_q   <= '0;
`ifdef MUX4_ARBITER_GAP_EN
         pend_q  <= 2'b00;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         n_en_q  <= n_en_d;
         busy_q  <= busy_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
`ifdef MUX4_ARBITER_GAP_EN
         pend_q  <= pend_d;
`endif
      end
   end

   assign gnt  = gnt_q;
   assign sel  = sel_q;
   assign n_en = n_en_q;
   assign busy = busy_q;

   logic unused_ok;
   assign unused_ok = ^other_win;

endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed self-checking bench for mux4_arbiter (HOLD_CYCLES=4), both GAP build options.
module tb_mux4_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       n_en;
   logic       busy;

   int pass_cnt = 0;
   int total    = 0;

`ifdef MUX4_ARBITER_GAP_EN
   localparam int GAPW = 1;
`else
   localparam int GAPW = 0;
`endif

   mux4_arbiter #(.HOLD_CYCLES(4), .CNT_W(3)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .gnt  (gnt),
      .sel  (sel),
      .n_en (n_en),
      .busy (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req = 4'b0000;
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({gnt, sel, n_en, busy} !== {4'b0000, 2'b00, 1'b1, 1'b0})
         $display("FAIL reset: got gnt=%b sel=%b n_en=%b busy=%b want 0000/00/1/0", gnt, sel, n_en, busy);
      else pass_cnt++;
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0100;
      tick();
      total++;
      if ({gnt, sel, n_en, busy} !== {4'b0100, 2'b10, 1'b0, 1'b1})
         $display("FAIL single_grant: got gnt=%b sel=%b n_en=%b busy=%b want 0100/10/0/1", gnt, sel, n_en, busy);
      else pass_cnt++;
      tick();
      tick();
      req = 4'b0000;
      tick();
      total++;
      if ({gnt, sel, n_en, busy} !== {4'b0000, 2'b10, 1'b1, 1'b0})
         $display("FAIL single_release: got gnt=%b sel=%b n_en=%b busy=%b want 0000/10/1/0", gnt, sel, n_en, busy);
      else pass_cnt++;
   endtask

   task automatic test_round_robin();
      int per;
      int nen_hi;
      logic [3:0] exp_gnt;
      per    = 4 + GAPW;
      nen_hi = 0;
      do_reset();
      req = 4'b1111;
      for (int t = 1; t <= 4 * per + 1; t++) begin
         tick();
         if (((t - 1) % per) < 4) exp_gnt = 4'b0001 << (((t - 1) / per) % 4);
         else exp_gnt = 4'b0000;
         if (n_en) nen_hi++;
         total++;
         if (gnt !== exp_gnt || n_en !== (exp_gnt == 4'b0000) || busy !== 1'b1)
            $display("FAIL rr_cycle%0d: got gnt=%b n_en=%b busy=%b want gnt=%b", t, gnt, n_en, busy, exp_gnt);
         else pass_cnt++;
      end
      total++;
      if (nen_hi !== 4 * GAPW)
         $display("FAIL rr_gap_count: got %0d want %0d", nen_hi, 4 * GAPW);
      else pass_cnt++;
   endtask

   task automatic test_solo_hold();
      int bad;
      bad = 0;
      do_reset();
      req = 4'b0010;
      for (int t = 0; t < 20; t++) begin
         tick();
         if (gnt !== 4'b0010 || n_en !== 1'b0 || sel !== 2'b01) bad++;
      end
      total++;
      if (bad != 0) $display("FAIL solo_hold: got %0d bad cycles want 0", bad);
      else pass_cnt++;
      req = 4'b0000;
      tick();
      total++;
      if (gnt !== 4'b0000 || busy !== 1'b0)
         $display("FAIL solo_release: got gnt=%b busy=%b want 0000/0", gnt, busy);
      else pass_cnt++;
   endtask

   task automatic test_early_drop();
      do_reset();
      req = 4'b0101;
      tick();
      total++;
      if (gnt !== 4'b0001) $display("FAIL early_first: got gnt=%b want 0001", gnt);
      else pass_cnt++;
      tick();
      req = 4'b0100;
      tick();
      if (GAPW == 1) begin
         total++;
         if (gnt !== 4'b0000 || n_en !== 1'b1 || busy !== 1'b1 || sel !== 2'b00)
            $display("FAIL early_gap: got gnt=%b n_en=%b busy=%b sel=%b want 0000/1/1/00", gnt, n_en, busy, sel);
         else pass_cnt++;
         tick();
      end
      total++;
      if (gnt !== 4'b0100 || sel !== 2'b10 || n_en !== 1'b0)
         $display("FAIL early_move: got gnt=%b sel=%b n_en=%b want 0100/10/0", gnt, sel, n_en);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 4'b1000;
      tick();
      total++;
      if (gnt !== 4'b1000 || sel !== 2'b11)
         $display("FAIL mid_owner3: got gnt=%b sel=%b want 1000/11", gnt, sel);
      else pass_cnt++;
      tick();
      rst = 1'b1;
      tick();
      total++;
      if ({gnt, sel, n_en, busy} !== {4'b0000, 2'b00, 1'b1, 1'b0})
         $display("FAIL mid_reset: got gnt=%b sel=%b n_en=%b busy=%b want 0000/00/1/0", gnt, sel, n_en, busy);
      else pass_cnt++;
      rst = 1'b0;
      req = 4'b1001;
      tick();
      total++;
      if (gnt !== 4'b0001 || sel !== 2'b00)
         $display("FAIL mid_after: got gnt=%b sel=%b want 0001/00", gnt, sel);
      else pass_cnt++;
   endtask

   task automatic test_gap_drop();
      do_reset();
      req = 4'b0010;
      tick();
      req = 4'b1000;
      tick();
      if (GAPW == 1) begin
         total++;
         if (gnt !== 4'b0000 || n_en !== 1'b1 || busy !== 1'b1 || sel !== 2'b01)
            $display("FAIL gapdrop_gap: got gnt=%b n_en=%b busy=%b sel=%b want 0000/1/1/01", gnt, n_en, busy, sel);
         else pass_cnt++;
         req = 4'b0000;
         tick();
      end else begin
         req = 4'b0000;
      end
      total++;
      if (gnt !== 4'b1000 || sel !== 2'b11 || n_en !== 1'b0)
         $display("FAIL gapdrop_grant: got gnt=%b sel=%b n_en=%b want 1000/11/0", gnt, sel, n_en);
      else pass_cnt++;
      tick();
      total++;
      if (gnt !== 4'b0000 || n_en !== 1'b1 || busy !== 1'b0 || sel !== 2'b11)
         $display("FAIL gapdrop_idle: got gnt=%b n_en=%b busy=%b sel=%b want 0000/1/0/11", gnt, n_en, busy, sel);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_solo_hold();
      test_early_drop();
      test_reset_mid();
      test_gap_drop();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
